alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Control sequencer that drives the shared ALU and its Y/Z staging registers for one register-class instruction at a time. It accepts an opcode on a start pulse, then steps through operand load, evaluate, and writeback, asserting the bus strobes in the required cycles. It sits between the instruction control unit and the datapath. Sequencing is selected by opcode class: binary, immediate, unary, mul/div, or illegal.

## Interface
- MULDIV_LAT, 4: evaluate cycles held for mul/div when MULDIV_WAIT_EN is defined; legal range 1..15.
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  5  ALU opcode; captured on the accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the captured opcode is illegal.
- rout_a  out  1  drives source register A onto the bus.
- rout_b  out  1  drives source register B onto the bus.
- cout  out  1  drives the sign-extended immediate onto the bus.
- yin  out  1  loads Y from the bus.
- zin  out  1  loads Z (HI/LO) from the ALU outputs.
- alu_op  out  5  opcode to the ALU; 5'b00000 outside EVAL.
- zlowout  out  1  drives Z-low onto the bus.
- zhighout  out  1  drives Z-high onto the bus.
- rin  out  1  writes the destination register.
- loin  out  1  writes the LO register.
- hiin  out  1  writes the HI register.

## Operation
- Opcode classes:
  - BIN: 3..11 (add, sub, and, or, shr, shra, shl, ror, rol).
  - IMM: 12..14 (addi, andi, ori).
  - MULDIV: 15, 16.
  - UNARY: 17, 18 (neg, not).
  - ILLEGAL: all other values.
- States: IDLE, LOADY, EVAL, WB_LO, WB_HI, DONE.
- IDLE
  - On start=1, capture op.
  - Next state: LOADY for BIN, IMM and MULDIV; EVAL for UNARY (the ALU uses only B, so Y is not loaded); DONE with the err flag set for ILLEGAL.
- LOADY: rout_a=1, yin=1. Next state: EVAL.
- EVAL
  - alu_op=captured op.
  - Bus source: rout_b=1 for BIN, MULDIV and UNARY; cout=1 for IMM.
  - zin=1 in the final EVAL cycle only.
  - Next state: WB_LO.
- WB_LO
  - zlowout=1.
  - rin=1, or loin=1 for MULDIV.
  - Next state: WB_HI for MULDIV, otherwise DONE.
- WB_HI: zhighout=1, hiin=1. Next state: DONE.
- DONE
  - done=1; err=1 if the captured op is ILLEGAL.
  - Next state: IDLE.
- All strobes are decoded from the state register and are zero in IDLE. At most one bus driver (rout_a, rout_b, cout, zlowout, zhighout) is active in any cycle.
- A start outside IDLE is ignored and not queued. A start in the same cycle DONE is active is also ignored; the earliest accepted restart is the cycle after done.

## Timing
- Reset: clr=1 forces IDLE immediately, including mid-sequence, and all outputs go to 0 (alu_op=5'b00000). The captured op clears to 0. An aborted sequence never produces done.
- Cycle counts below are measured from the edge that accepts start (cycle 0) to done high:
  - BIN/IMM: done in cycle 4.
  - UNARY: done in cycle 3.
  - MULDIV: done in cycle 5, or 4+MULDIV_LAT with the wait feature.
  - ILLEGAL: done and err in cycle 1.
- busy rises in cycle 1 and falls in the cycle after DONE.
- The ALU is combinational. alu_op and the bus source are stable for the whole EVAL cycle, and zin captures at the end of that cycle.

## Configuration
- MULDIV_WAIT_EN defined:
  - For MULDIV only, EVAL lasts MULDIV_LAT cycles, counted by a 4-bit down-counter loaded when EVAL is entered.
  - alu_op and rout_b are held for all EVAL cycles; zin is asserted only when the counter reaches 1.
  - Other classes are unaffected.
- MULDIV_WAIT_EN undefined: EVAL is a single cycle for every class; MULDIV_LAT is ignored and no counter is built.

## Structure
- Shared package/include alu_ctrl_pkg holds:
  - the 5-bit opcode constants, matching the ALU encoding;
  - the class encoding (BIN, IMM, MULDIV, UNARY, ILLEGAL);
  - the state encoding.
- Sub-module op_class_decode: a combinational map from the 5-bit opcode to the class; reused by the instruction control unit.

## Test plan
- add: op=5'b00011, start in cycle 0. Cycle 1: rout_a and yin. Cycle 2: rout_b, zin, alu_op=00011. Cycle 3: zlowout and rin. Cycle 4: done=1 with err=0. Then back to IDLE.
- addi: op=5'b01100. Same cycle count as add, but cycle 2 has cout=1 and rout_b=0.
- not: op=5'b10010.
  - Cycle 1 is EVAL: rout_b and zin, with no yin at any point.
  - Cycle 2: zlowout and rin. Cycle 3: done.
- mul with MULDIV_WAIT_EN and MULDIV_LAT=4: op=5'b01111.
  - EVAL spans cycles 2..5, with zin only in cycle 5.
  - Cycle 6: loin. Cycle 7: hiin and zhighout. Cycle 8: done.
  - Without the macro, done falls in cycle 5.
- Illegal and ignored start: op=5'b11111 gives done=1 and err=1 in cycle 1 and no strobes. A second start during busy of an add gives no extra sequence.
- Mid-sequence reset: clr pulse during the mul EVAL. All outputs go to 0 asynchronously and done never pulses. A start after clr deasserts is accepted normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, operation-class and sequencer-state encodings
// for the ALU control sequencer and the instruction control unit.
package alu_ctrl_pkg;

   localparam logic [4:0] OP_NONE = 5'd0;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;

   typedef enum logic [2:0] {
      CLS_BIN,
      CLS_IMM,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_ILL
   } op_class_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADY,
      S_EVAL,
      S_WB_LO,
      S_WB_HI,
      S_DONE
   } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request handshake and datapath strobes of the ALU sequencer.
// master = instruction control side, slave = sequencer.
interface alu_seq_ctrl_if;

   logic       start;
   logic [4:0] op;
   logic       busy;
   logic       done;
   logic       err;
   logic       rout_a;
   logic       rout_b;
   logic       cout;
   logic       yin;
   logic       zin;
   logic [4:0] alu_op;
   logic       zlowout;
   logic       zhighout;
   logic       rin;
   logic       loin;
   logic       hiin;

   modport master (
      output start, op,
      input  busy, done, err, rout_a, rout_b, cout, yin, zin,
      input  alu_op, zlowout, zhighout, rin, loin, hiin
   );

   modport slave (
      input  start, op,
      output busy, done, err, rout_a, rout_b, cout, yin, zin,
      output alu_op, zlowout, zhighout, rin, loin, hiin
   );

endinterface

// File: rtl/op_class_decode.sv
// Combinational opcode -> operation class map, shared with the
// instruction control unit.
module op_class_decode
   import alu_ctrl_pkg::*;
(
   input  logic [4:0] op,
   output op_class_t  cls
);

   always_comb begin
      cls = CLS_ILL;
      unique case (1'b1)
         (op >= OP_ADD  && op <= OP_ROL): cls = CLS_BIN;
         (op >= OP_ADDI && op <= OP_ORI): cls = CLS_IMM;
         (op == OP_MUL  || op == OP_DIV): cls = CLS_MULDIV;
         (op == OP_NEG  || op == OP_NOT): cls = CLS_UNARY;
         default:                         cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU load/evaluate/writeback sequencer. Define MULDIV_WAIT_EN to
// hold EVAL for MULDIV_LAT cycles on mul/div.
module alu_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT = 4
) (
   input logic           clk,
   input logic           clr,
   alu_seq_ctrl_if.slave bus
);

   if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_lat_chk
      $error("MULDIV_LAT must be within 1..15");
   end

   state_t    state, nxt;
   logic [4:0] op_q;
   op_class_t cls_in, cls_q;
   logic      eval_last;

   op_class_decode u_dec (
      .op  (bus.op),
      .cls (cls_in)
   );

`ifdef MULDIV_WAIT_EN
   logic [3:0] cnt;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         cnt <= '0;
      else if (nxt == S_EVAL && state != S_EVAL)
         cnt <= 4'(MULDIV_LAT);
      else if (state == S_EVAL && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   assign eval_last = (cls_q != CLS_MULDIV) || (cnt == 4'd1);
`else
   assign eval_last = 1'b1;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= S_IDLE;
         op_q  <= '0;
         cls_q <= CLS_ILL;
      end else begin
         state <= nxt;
         if (state == S_IDLE && bus.start) begin
            op_q  <= bus.op;
            cls_q <= cls_in;
         end
      end
   end

   always_comb begin
      nxt          = state;
      bus.busy     = (state != S_IDLE);
      bus.done     = 1'b0;
      bus.err      = 1'b0;
      bus.rout_a   = 1'b0;
      bus.rout_b   = 1'b0;
      bus.cout     = 1'b0;
      bus.yin      = 1'b0;
      bus.zin      = 1'b0;
      bus.alu_op   = OP_NONE;
      bus.zlowout  = 1'b0;
      bus.zhighout = 1'b0;
      bus.rin      = 1'b0;
      bus.loin     = 1'b0;
      bus.hiin     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (cls_in == CLS_ILL)
                  nxt = S_DONE;
               else if (cls_in == CLS_UNARY)
                  nxt = S_EVAL;
               else
                  nxt = S_LOADY;
            end
         end
         S_LOADY: begin
            bus.rout_a = 1'b1;
            bus.yin    = 1'b1;
            nxt        = S_EVAL;
         end
         S_EVAL: begin
            bus.alu_op = op_q;
            bus.cout   = (cls_q == CLS_IMM);
            bus.rout_b = (cls_q != CLS_IMM);
            bus.zin    = eval_last;
            if (eval_last)
               nxt = S_WB_LO;
         end
         S_WB_LO: begin
            bus.zlowout = 1'b1;
            bus.loin    = (cls_q == CLS_MULDIV);
            bus.rin     = (cls_q != CLS_MULDIV);
            nxt = (cls_q == CLS_MULDIV) ? S_WB_HI : S_DONE;
         end
         S_WB_HI: begin
            bus.zhighout = 1'b1;
            bus.hiin     = 1'b1;
            nxt          = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            bus.err  = (cls_q == CLS_ILL);
            nxt      = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule
